keylock_fsm: RTL and testbench
==============================

# keylock_fsm

Clocked, parametrised successor to the asynchronous keypad lock. Accepts one digit per `key_valid` strobe and compares a full-length entry against a stored code of `CODE_LEN` digits. A correct entry unlocks the block. Failed entries are counted, and `MAX_FAIL` consecutive failures force a timed lockout with an alarm. Sits between the keypad debouncer/encoder and the actuator driver.

## Interface
- `DIGIT_W`, 4 — bits per key digit.
- `CODE_LEN`, 6 — digits per code entry (≥1).
- `MAX_FAIL`, 3 — consecutive failed entries that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 16 — clock cycles spent in lockout (≥1).
- `DEFAULT_CODE`, 24'h335256 — reset code, `CODE_LEN*DIGIT_W` bits; first digit in MS digit slot.
- `clk` input 1 — single clock; all state changes on rising edge.
- `reset` input 1 — synchronous, active-high.
- `key_valid` input 1 — one-cycle strobe; `key` sampled when high.
- `key` input DIGIT_W — digit value, compared raw (no range check).
- `relock` input 1 — relock / abort current entry.
- `prog` input 1 — start code programming (used only with `KEYLOCK_PROG_EN`).
- `locked` output 1 — 0 only in UNLOCKED/PROG.
- `alarm` output 1 — 1 only in LOCKOUT.
- `fail_count` output $clog2(MAX_FAIL+1) — consecutive failed entries.
- `digit_idx` output $clog2(CODE_LEN+1) — digits accepted in current entry/programming.

## Operation
- States: ENTRY, UNLOCKED, LOCKOUT, PROG (PROG only with macro).
- Reset: state ENTRY, `locked`=1, `alarm`=0, `fail_count`=0, `digit_idx`=0, and code register = `DEFAULT_CODE`.
- ENTRY, digit accepted:
  - Compare `key` with code digit `digit_idx`.
  - OR any mismatch into a sticky `err` flag.
  - Increment `digit_idx`.
  - No early abort: the entry always runs a full `CODE_LEN` digits.
- ENTRY, on accepting the `CODE_LEN`-th digit:
  - `digit_idx` goes to 0.
  - All digits matched → UNLOCKED, `fail_count` goes to 0.
  - Otherwise `fail_count`+1. If the new value equals `MAX_FAIL` → LOCKOUT; else remain in ENTRY. `err` cleared.
- ENTRY + `relock`: discard the partial entry (`digit_idx`=0, `err`=0). `fail_count` is unchanged.
- UNLOCKED:
  - `key_valid` ignored.
  - `relock` → ENTRY.
  - `prog` (macro defined, no `relock`) → PROG.
- LOCKOUT:
  - Keys, `relock` and `prog` ignored.
  - A down-counter loaded with `LOCKOUT_CYCLES-1` on entry counts to 0.
  - Then → ENTRY with `fail_count`=0.
- Priority within a cycle: `reset` > `relock` > `prog` > `key_valid`.

## Timing
- All outputs are registered. The state change is visible the cycle after the sampling edge.
- Final correct digit sampled at edge N → `locked`=0 from edge N.
- MAX_FAIL-th bad entry completes at edge N → `alarm`=1 for exactly `LOCKOUT_CYCLES` cycles. `alarm`=0 and `fail_count`=0 from edge N+`LOCKOUT_CYCLES`.
- `relock` at edge N → `locked`=1 from edge N.
- Back-to-back `key_valid` on every cycle is supported; there is no throughput limit.
- `fail_count` saturates at `MAX_FAIL` and never wraps.
- `reset` mid-entry, mid-lockout or mid-programming restores all reset values, including `DEFAULT_CODE`.

## Configuration
- Macro: `KEYLOCK_PROG_EN`.
- Defined — code programming is enabled:
  - In PROG, each accepted digit is written to shadow slot `digit_idx`.
  - After the `CODE_LEN`-th digit, the shadow is copied to the code register in one cycle, `digit_idx`=0, and the state returns to UNLOCKED.
  - `relock` in PROG aborts the programming: the code register is unchanged and the state goes to ENTRY.
  - `locked` stays 0 throughout PROG.
- Undefined:
  - The code is the constant `DEFAULT_CODE`.
  - `prog` is ignored; the PROG state and shadow register are not built.

## Test plan
- Reset, then keys 3,3,5,2,5,6 with `key_valid` on consecutive cycles → `locked`=0 one cycle after the sample of digit 6; `fail_count`=0.
- Keys 3,3,5,2,5,7, then a correct entry → `fail_count`=1 after the bad entry; unlock on the 2nd entry; `fail_count` returns to 0.
- Three wrong 6-digit entries → `alarm`=1 for 16 cycles; digits sent during alarm are ignored; then `fail_count`=0 and a correct entry unlocks.
- Keys 3,3,5 then `relock`, then a full correct entry → unlock (partial entry discarded). `relock` asserted together with `key_valid` → the digit is dropped.
- With `KEYLOCK_PROG_EN`: unlock, `prog`, keys 1,2,3,4,5,6, `relock` → 3,3,5,2,5,6 now fails and 1,2,3,4,5,6 unlocks. `reset` restores 335256.
- Assert `reset` during lockout and during a partial entry → next cycle `locked`=1, `alarm`=0, `fail_count`=0, `digit_idx`=0.

Source files
------------

// File: rtl/keylock_fsm.sv
// -----------------------------------------------------------------------------
// keylock_fsm
//
// Clocked keypad lock. Digits arrive one per key_valid strobe from the keypad
// debouncer/encoder. A full CODE_LEN-digit entry is compared against the stored
// code, and a match unlocks the block. Consecutive failed entries are counted.
// MAX_FAIL of them force a timed lockout with the alarm raised.
//
// Optional feature macro: KEYLOCK_PROG_EN
//   Defined   : while UNLOCKED, a prog pulse enters PROG. The next CODE_LEN
//               digits become the new code.
//   Undefined : the code is the constant DEFAULT_CODE and prog is ignored.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   key_valid  in   one-cycle strobe qualifying key
//   key        in   [DIGIT_W-1:0] digit value
//   relock     in   relock / abort the current entry
//   prog       in   start code programming (KEYLOCK_PROG_EN only)
//   locked     out  0 only in UNLOCKED / PROG
//   alarm      out  1 only in LOCKOUT
//   fail_count out  consecutive failed entries
//   digit_idx  out  digits accepted in the current entry / programming
// -----------------------------------------------------------------------------
module keylock_fsm #(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 6,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 24'h335256
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              key_valid,
  input  logic [DIGIT_W-1:0]                key,
  input  logic                              relock,
  input  logic                              prog,
  output logic                              locked,
  output logic                              alarm,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_count,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_idx
);

  localparam int FC_W  = $clog2(MAX_FAIL + 1);
  localparam int DI_W  = $clog2(CODE_LEN + 1);
  localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int CODE_W = CODE_LEN * DIGIT_W;

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
`ifdef KEYLOCK_PROG_EN
    , ST_PROG   = 2'd3
`endif
  } state_t;

  // Registers
  state_t              r_state;
  logic [DI_W-1:0]     r_digit_idx;
  logic                r_err;
  logic [FC_W-1:0]     r_fail_count;
  logic [CNT_W-1:0]    r_lock_cnt;
  logic                r_locked;
  logic                r_alarm;

  // Next-state wires
  state_t              w_state_next;
  logic [DI_W-1:0]     w_digit_idx_next;
  logic                w_err_next;
  logic [FC_W-1:0]     w_fail_count_next;
  logic [CNT_W-1:0]    w_lock_cnt_next;
  logic                w_locked_next;
  logic                w_alarm_next;

  // Code storage
  logic [CODE_W-1:0]   w_code;
  logic [DIGIT_W-1:0]  w_code_digit [CODE_LEN];
  logic [DIGIT_W-1:0]  w_exp_digit;
  logic                w_err_acc;
  logic                w_last;
  logic [FC_W-1:0]     w_fail_inc;

`ifdef KEYLOCK_PROG_EN
  logic [CODE_W-1:0]   r_code;
  logic [CODE_W-1:0]   r_shadow;
  logic [CODE_W-1:0]   w_code_next;
  logic [CODE_W-1:0]   w_shadow_next;
  logic [CODE_W-1:0]   w_shadow_wr;

  assign w_code = r_code;
`else
  logic                w_unused_prog;

  assign w_code        = DEFAULT_CODE;
  assign w_unused_prog = prog;
`endif

  // Digit 0 of the code lives in the most-significant digit slot.
  genvar gi;
  generate
    for (gi = 0; gi < CODE_LEN; gi++) begin : g_code_digit
      assign w_code_digit[gi] = w_code[(CODE_LEN-1-gi)*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  always_comb begin
    w_exp_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (r_digit_idx == DI_W'(i)) w_exp_digit = w_code_digit[i];
    end
  end

  // The error flag is sticky across the entry, so a wrong digit never aborts
  // early and an observer cannot learn which position was wrong.
  assign w_err_acc  = r_err | (key != w_exp_digit);
  assign w_last     = (r_digit_idx == DI_W'(CODE_LEN - 1));
  assign w_fail_inc = r_fail_count + 1'b1;

`ifdef KEYLOCK_PROG_EN
  // Shadow with the current key written into slot digit_idx.
  always_comb begin
    w_shadow_wr = r_shadow;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (r_digit_idx == DI_W'(i)) w_shadow_wr[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = key;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_ENTRY;
      r_digit_idx  <= '0;
      r_err        <= 1'b0;
      r_fail_count <= '0;
      r_lock_cnt   <= '0;
      r_locked     <= 1'b1;
      r_alarm      <= 1'b0;
`ifdef KEYLOCK_PROG_EN
      r_code       <= DEFAULT_CODE;
      r_shadow     <= '0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_digit_idx  <= w_digit_idx_next;
      r_err        <= w_err_next;
      r_fail_count <= w_fail_count_next;
      r_lock_cnt   <= w_lock_cnt_next;
      r_locked     <= w_locked_next;
      r_alarm      <= w_alarm_next;
`ifdef KEYLOCK_PROG_EN
      r_code       <= w_code_next;
      r_shadow     <= w_shadow_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: relock > prog > key_valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_digit_idx_next  = r_digit_idx;
    w_err_next        = r_err;
    w_fail_count_next = r_fail_count;
    w_lock_cnt_next   = r_lock_cnt;
`ifdef KEYLOCK_PROG_EN
    w_code_next       = r_code;
    w_shadow_next     = r_shadow;
`endif

    case (r_state)
      ST_ENTRY: begin
        if (relock) begin
          w_digit_idx_next = '0;
          w_err_next       = 1'b0;
        end else if (key_valid) begin
          if (w_last) begin
            w_digit_idx_next = '0;
            w_err_next       = 1'b0;
            if (!w_err_acc) begin
              w_state_next      = ST_UNLOCKED;
              w_fail_count_next = '0;
            end else if (w_fail_inc >= FC_W'(MAX_FAIL)) begin
              w_fail_count_next = FC_W'(MAX_FAIL);
              w_state_next      = ST_LOCKOUT;
              w_lock_cnt_next   = CNT_W'(LOCKOUT_CYCLES - 1);
            end else begin
              w_fail_count_next = w_fail_inc;
            end
          end else begin
            w_digit_idx_next = r_digit_idx + 1'b1;
            w_err_next       = w_err_acc;
          end
        end
      end

      ST_UNLOCKED: begin
        if (relock) begin
          w_state_next     = ST_ENTRY;
          w_digit_idx_next = '0;
          w_err_next       = 1'b0;
`ifdef KEYLOCK_PROG_EN
        end else if (prog) begin
          w_state_next     = ST_PROG;
          w_digit_idx_next = '0;
`endif
        end
      end

      // Counter was loaded with LOCKOUT_CYCLES-1 on entry, so the exit edge
      // lands exactly LOCKOUT_CYCLES cycles after the entry edge.
      ST_LOCKOUT: begin
        if (r_lock_cnt == '0) begin
          w_state_next      = ST_ENTRY;
          w_fail_count_next = '0;
          w_digit_idx_next  = '0;
          w_err_next        = 1'b0;
        end else begin
          w_lock_cnt_next = r_lock_cnt - 1'b1;
        end
      end

`ifdef KEYLOCK_PROG_EN
      ST_PROG: begin
        if (relock) begin
          w_state_next     = ST_ENTRY;
          w_digit_idx_next = '0;
          w_err_next       = 1'b0;
        end else if (key_valid) begin
          w_shadow_next = w_shadow_wr;
          if (w_last) begin
            w_code_next      = w_shadow_wr;
            w_digit_idx_next = '0;
            w_state_next     = ST_UNLOCKED;
          end else begin
            w_digit_idx_next = r_digit_idx + 1'b1;
          end
        end
      end
`endif

      default: begin
        w_state_next     = ST_ENTRY;
        w_digit_idx_next = '0;
        w_err_next       = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic, decoded from the next state so the outputs come out of
  // registers and change on the same edge as the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_locked_next = 1'b1;
    w_alarm_next  = 1'b0;
    case (w_state_next)
      ST_UNLOCKED: w_locked_next = 1'b0;
`ifdef KEYLOCK_PROG_EN
      ST_PROG:     w_locked_next = 1'b0;
`endif
      ST_LOCKOUT:  w_alarm_next  = 1'b1;
      default:     w_locked_next = 1'b1;
    endcase
  end

  assign locked     = r_locked;
  assign alarm      = r_alarm;
  assign fail_count = r_fail_count;
  assign digit_idx  = r_digit_idx;

endmodule

// File: tb/tb_keylock_fsm.sv
module tb_keylock_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key;
  logic       relock;
  logic       prog;
  logic       locked;
  logic       alarm;
  logic [1:0] fail_count;
  logic [2:0] digit_idx;

  int checks = 0;
  int errors = 0;

  keylock_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key        (key),
    .relock     (relock),
    .prog       (prog),
    .locked     (locked),
    .alarm      (alarm),
    .fail_count (fail_count),
    .digit_idx  (digit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Six digits on consecutive cycles.
  task automatic enter6(input logic [23:0] code);
    for (int i = 0; i < 6; i++) begin
      key       = code[23-4*i -: 4];
      key_valid = 1'b1;
      step();
    end
    key_valid = 1'b0;
  endtask

  task automatic do_relock();
    relock = 1'b1;
    step();
    relock = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key = '0; relock = 1'b0; prog = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst_locked", locked, 1); chk("rst_alarm", alarm, 0);
    chk("rst_fail", fail_count, 0); chk("rst_idx", digit_idx, 0);
    $display("txn reset: locked=%0d alarm=%0d fail=%0d idx=%0d", locked, alarm, fail_count, digit_idx);

    // Correct code back-to-back
    for (int i = 0; i < 3; i++) begin
      key = (i == 2) ? 4'd5 : 4'd3; key_valid = 1'b1; step();
    end
    key_valid = 1'b0;
    chk("ok_idx3", digit_idx, 3);
    chk("ok_locked_mid", locked, 1);
    key = 4'd2; key_valid = 1'b1; step();
    key = 4'd5; step();
    key = 4'd6; step();
    key_valid = 1'b0;
    chk("ok_unlock", locked, 0); chk("ok_fail", fail_count, 0); chk("ok_idx0", digit_idx, 0);
    $display("txn correct entry: locked=%0d fail=%0d", locked, fail_count);
    // Keys ignored while unlocked
    key = 4'd1; key_valid = 1'b1; step(); key_valid = 1'b0;
    chk("unl_key_ignored", digit_idx, 0);
    do_relock();
    chk("relock_locked", locked, 1);
    $display("txn relock: locked=%0d", locked);

    // One bad entry (only last digit wrong), then a good one
    enter6(24'h335257);
    chk("bad1_fail", fail_count, 1); chk("bad1_locked", locked, 1); chk("bad1_idx", digit_idx, 0);
    $display("txn bad entry: fail=%0d", fail_count);
    enter6(24'h335256);
    chk("good2_unlock", locked, 0); chk("good2_fail", fail_count, 0);
    $display("txn good entry: locked=%0d fail=%0d", locked, fail_count);
    do_relock();

    // Three bad entries -> lockout
    enter6(24'h000000);
    chk("lk_fail1", fail_count, 1);
    enter6(24'h123456);
    chk("lk_fail2", fail_count, 2); chk("lk_alarm_pre", alarm, 0);
    enter6(24'h335250);
    chk("lk_alarm_on", alarm, 1); chk("lk_fail3", fail_count, 3); chk("lk_locked", locked, 1);
    $display("txn lockout start: alarm=%0d fail=%0d", alarm, fail_count);
    // Cycles 1..15 of lockout: alarm stays up, keys and relock ignored
    for (int k = 1; k < 16; k++) begin
      key = 4'd3; key_valid = 1'b1; relock = (k == 7);
      step();
      chk($sformatf("lk_alarm_c%0d", k), alarm, 1);
    end
    key_valid = 1'b0; relock = 1'b0;
    chk("lk_idx_ignored", digit_idx, 0); chk("lk_fail_hold", fail_count, 3);
    step();
    chk("lk_alarm_off", alarm, 0); chk("lk_fail_clr", fail_count, 0);
    chk("lk_locked_after", locked, 1);
    $display("txn lockout end: alarm=%0d fail=%0d", alarm, fail_count);
    enter6(24'h335256);
    chk("lk_then_unlock", locked, 0);
    do_relock();

    // Partial entry discarded by relock
    key_valid = 1'b1;
    key = 4'd3; step(); key = 4'd3; step(); key = 4'd5; step();
    key_valid = 1'b0;
    chk("part_idx3", digit_idx, 3);
    do_relock();
    chk("part_idx0", digit_idx, 0); chk("part_fail", fail_count, 0);
    enter6(24'h335256);
    chk("part_unlock", locked, 0);
    $display("txn partial+relock then correct: locked=%0d", locked);
    do_relock();

    // relock together with key_valid: digit dropped
    key = 4'd3; key_valid = 1'b1; relock = 1'b1; step();
    key_valid = 1'b0; relock = 1'b0;
    chk("rk_idx", digit_idx, 0);
    enter6(24'h335256);
    chk("rk_unlock", locked, 0); chk("rk_fail", fail_count, 0);
    $display("txn relock+key dropped: locked=%0d", locked);
    do_relock();

    // Reset during a partial entry (with an accumulated failure)
    enter6(24'h111111);
    key = 4'd3; key_valid = 1'b1; step(); step(); key_valid = 1'b0;
    chk("rp_idx_pre", digit_idx, 2);
    do_reset();
    chk("rp_locked", locked, 1); chk("rp_alarm", alarm, 0);
    chk("rp_fail", fail_count, 0); chk("rp_idx", digit_idx, 0);
    $display("txn reset mid-entry: fail=%0d idx=%0d", fail_count, digit_idx);

    // Reset during lockout
    enter6(24'h000000); enter6(24'h000000); enter6(24'h000000);
    step(); step();
    chk("rl_alarm_pre", alarm, 1);
    do_reset();
    chk("rl_locked", locked, 1); chk("rl_alarm", alarm, 0);
    chk("rl_fail", fail_count, 0); chk("rl_idx", digit_idx, 0);
    $display("txn reset mid-lockout: alarm=%0d fail=%0d", alarm, fail_count);
    enter6(24'h335256);
    chk("rl_unlock", locked, 0);
    do_relock();

`ifdef KEYLOCK_PROG_EN
    // Program a new code
    enter6(24'h335256);
    prog = 1'b1; step(); prog = 1'b0;
    chk("pg_locked_in_prog", locked, 0);
    enter6(24'h123456);
    chk("pg_locked_after", locked, 0); chk("pg_idx", digit_idx, 0);
    do_relock();
    enter6(24'h335256);
    chk("pg_old_fails", fail_count, 1); chk("pg_old_locked", locked, 1);
    enter6(24'h123456);
    chk("pg_new_unlocks", locked, 0);
    $display("txn program code 123456: locked=%0d", locked);
    do_relock();
    // Aborted programming leaves the code unchanged
    enter6(24'h123456);
    prog = 1'b1; step(); prog = 1'b0;
    key = 4'd9; key_valid = 1'b1; step(); step(); key_valid = 1'b0;
    do_relock();
    chk("pg_abort_locked", locked, 1);
    enter6(24'h123456);
    chk("pg_abort_keep", locked, 0);
    do_relock();
    do_reset();
    enter6(24'h123456);
    chk("pg_rst_new_fails", locked, 1);
    enter6(24'h335256);
    chk("pg_rst_default", locked, 0);
    $display("txn reset restores default: locked=%0d", locked);
    do_relock();
`else
    // prog ignored while unlocked
    enter6(24'h335256);
    prog = 1'b1; step(); prog = 1'b0;
    key = 4'd1; key_valid = 1'b1; step(); key_valid = 1'b0;
    chk("np_idx", digit_idx, 0); chk("np_locked", locked, 0);
    do_relock();
    enter6(24'h335256);
    chk("np_code_kept", locked, 0);
    $display("txn prog ignored: locked=%0d", locked);
    do_relock();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
